syndown_timer: RTL and testbench
================================

Name: syndown_timer

Overview:
- Programmable synchronous down-counting interval timer; the count-down counterpart of the up-counter chain used throughout the block library.
- Holds a reload value and decrements on each enabled tick (CI) to zero.
- At zero it issues a terminal-count pulse and a borrow-out for cascading, then either reloads (auto mode) or halts (one-shot).
- Sits behind the register file as a sound/video/blitter interval timer; CI is driven by a prescaler or by the BO of a lower stage.

Parameters:
- WIDTH, 16, counter and reload register width in bits (2..32).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- D  input  WIDTH  reload data.
- WRL  input  1  active-low reload-register write strobe.
- STRT  input  1  active-high start pulse: load counter from reload value and run.
- STOP  input  1  active-high stop pulse: halt and hold the current count.
- AUTO  input  1  1 = auto-reload at terminal count; 0 = one-shot.
- CI  input  1  active-high count enable (tick / borrow-in).
- Q  output  WIDTH  current count.
- QB  output  WIDTH  bitwise inverse of Q.
- TC  output  1  registered terminal-count pulse, one cycle wide.
- BO  output  1  combinational borrow-out: RUN & CI & (Q==0).
- RUNNING  output  1  high in state RUN.

Behaviour:
- Reset (RESET=1 at the clock edge, overrides all other inputs):
  - Q=0, reload=0, TC=0, state=IDLE.
  - So QB=all ones, BO=0 and RUNNING=0.
  - A reset during RUN aborts immediately and no TC is produced.
- Reload register:
  - WRL=0 latches D at the edge, in any state.
  - Writing does not disturb a running count unless STRT is asserted in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - Q holds and CI is ignored.
  - STRT: Q <= reload, go to RUN.
- RUN, with CI=1:
  - Q!=0: Q <= Q-1.
  - Q==0: TC=1 next cycle. AUTO=1: Q <= reload, stay in RUN. AUTO=0: Q stays 0, go to DONE.
- RUN, with CI=0: Q holds.
- DONE:
  - Q holds 0 and CI is ignored.
  - STRT reloads and goes to RUN.
- STOP from RUN or DONE: go to IDLE, Q holds.
- STRT during RUN: restart, Q <= reload, no TC.
- Simultaneous events, by priority:
  - RESET > STOP > STRT > count.
  - WRL=0 together with STRT: the counter loads the new D directly (write-through) and reload <= D.
  - STRT in the same cycle as a zero-count tick: the restart wins and TC is suppressed.
  - AUTO sampled at the terminal-count edge only.
- Arithmetic:
  - Modulo 2^WIDTH; no underflow past 0 is possible (0 triggers reload/halt).
  - Period in auto mode = reload+1 ticks.
  - Reload 0 with AUTO=1 gives TC on every tick.
- Latency:
  - Q reflects a load or decrement one cycle after the edge.
  - TC is asserted in the cycle following the tick at which Q==0.
  - BO is same-cycle and is used as CI of the next cascaded stage.
- TC is a pulse, deasserted the following cycle unless another terminal count occurs (reload 0, continuous CI).

Decomposition:
- Shared package holds:
  - the state enum (IDLE/RUN/DONE, 2-bit encoding 00/01/10);
  - the localparam for default WIDTH;
  - a zero-detect function.
- Natural sub-module: syndcnt_bit, a one-bit down-count slice with:
  - inputs D, CLK, CLR, LDL, BI;
  - outputs Q, QB, BO;
  - the slice toggles when BI=1, loads when LDL=0, clears when CLR=1;
  - BO = BI & QB.
- The timer instantiates WIDTH slices in a borrow chain plus the control FSM.

Test Plan:
- Reset and one-shot count:
  - Stimulus: reset, WRL=0 with D=3, STRT, then CI held at 1.
  - Required response: Q sequence is 3,2,1,0; TC=1 exactly one cycle after the tick at Q==0; state DONE; Q holds 0; RUNNING=0.
- Auto reload:
  - Stimulus: D=2, AUTO=1, STRT, CI=1 for 9 cycles.
  - Required response: Q sequence 2,1,0,2,1,0,2,1,0; TC pulses every 3rd cycle; BO=1 on each Q==0 cycle.
- Gated ticks and stop:
  - Stimulus: D=5, CI alternating 1/0, STOP asserted at Q=3.
  - Required response: Q decrements only on CI=1 cycles; after STOP, Q holds 3, state IDLE, and further CI has no effect.
- Simultaneous events:
  - Stimulus 1: WRL=0 with D=7 and STRT in the same cycle → Q=7 next cycle.
  - Stimulus 2: STRT and STOP together → IDLE.
  - Stimulus 3: STRT on a zero-count tick → reload, no TC.
- Reset mid-run and edge values:
  - Stimulus 1: RESET while Q=4 in RUN → Q=0, TC=0, reload=0 next cycle.
  - Stimulus 2: reload 0 with AUTO=1 → TC=1 every tick.
  - Stimulus 3: reload all ones (0xFFFF) → 65536-tick period.
- Cascade:
  - Stimulus: two 4-bit instances, BO of the low stage drives CI of the high stage, both loaded with 0x1 and 0x2.
  - Required response: high stage decrements only when the low stage is at 0 with CI=1.

Source files
------------

// File: rtl/syndown_timer_pkg.sv
// Shared definitions for the syndown_timer interval timer: control states,
// default counter width and a zero-detect helper.
package syndown_timer_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_zero(input logic [31:0] v);
    return (v == 32'd0);
  endfunction

endpackage

// File: rtl/syndown_timer_bit.sv
// One-bit down-count slice: clear beats load beats toggle; borrow ripples
// to the next slice only when this bit is already zero.
module syndcnt_bit (
  input  logic CLK,
  input  logic CLR,
  input  logic LDL,
  input  logic BI,
  input  logic D,
  output logic Q,
  output logic QB,
  output logic BO
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (!LDL) begin
      q_d = D;
    end else if (BI) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign QB = ~q_q;
  assign BO = BI & ~q_q;

endmodule

// File: rtl/syndown_timer.sv
// Programmable down-counting interval timer: a borrow chain of one-bit
// slices plus the IDLE/RUN/DONE control that decides loads and terminal counts.
module syndown_timer
  import syndown_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             WRL,
  input  logic             STRT,
  input  logic             STOP,
  input  logic             AUTO,
  input  logic             CI,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QB,
  output logic             TC,
  output logic             BO,
  output logic             RUNNING
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   borrow;
  logic             run;
  logic             q_zero;

  assign run       = (state_q == ST_RUN);
  assign q_zero    = is_zero(32'(Q));
  assign borrow[0] = run & CI;

  // Any load overrides the chain's toggling, so a zero-count tick never wraps.
  always_comb begin
    state_d  = state_q;
    reload_d = WRL ? reload_q : D;
    tc_d     = 1'b0;
    load     = 1'b0;
    load_val = Q;
    if (STOP) begin
      load    = 1'b1;
      state_d = ST_IDLE;
    end else if (STRT) begin
      load     = 1'b1;
      load_val = WRL ? reload_q : D;
      state_d  = ST_RUN;
    end else if (run && CI && q_zero) begin
      tc_d = 1'b1;
      load = 1'b1;
      if (AUTO) begin
        load_val = reload_q;
      end else begin
        load_val = '0;
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    syndcnt_bit u_bit (
      .CLK (CLK),
      .CLR (RESET),
      .LDL (~load),
      .BI  (borrow[i]),
      .D   (load_val[i]),
      .Q   (Q[i]),
      .QB  (QB[i]),
      .BO  (borrow[i+1])
    );
  end

  assign BO      = borrow[WIDTH];
  assign TC      = tc_q;
  assign RUNNING = run;

endmodule

// File: tb/tb_syndown_timer.sv
// Directed bench for syndown_timer: a 16-bit instance and a cascaded pair of
// 4-bit instances, checked every cycle against a behavioural model.
module tb_syndown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wrl, strt, stop, auto, ci, c_ci;
  logic [15:0] d;
  logic [3:0]  c_dlo, c_dhi;

  logic [15:0] q, qb;
  logic        tc, bo, running;
  logic [3:0]  lo_q, lo_qb, hi_q, hi_qb;
  logic        lo_tc, lo_bo, lo_run, hi_tc, hi_bo, hi_run;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  syndown_timer #(.WIDTH(16)) dut (
    .CLK(clk), .RESET(rst), .D(d), .WRL(wrl), .STRT(strt), .STOP(stop),
    .AUTO(auto), .CI(ci), .Q(q), .QB(qb), .TC(tc), .BO(bo), .RUNNING(running)
  );

  syndown_timer #(.WIDTH(4)) dut_lo (
    .CLK(clk), .RESET(rst), .D(c_dlo), .WRL(wrl), .STRT(strt), .STOP(stop),
    .AUTO(auto), .CI(c_ci), .Q(lo_q), .QB(lo_qb), .TC(lo_tc), .BO(lo_bo),
    .RUNNING(lo_run)
  );

  syndown_timer #(.WIDTH(4)) dut_hi (
    .CLK(clk), .RESET(rst), .D(c_dhi), .WRL(wrl), .STRT(strt), .STOP(stop),
    .AUTO(auto), .CI(lo_bo), .Q(hi_q), .QB(hi_qb), .TC(hi_tc), .BO(hi_bo),
    .RUNNING(hi_run)
  );

  // Model state: st 0=idle 1=run 2=done
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] rl;
    logic [1:0]  st;
    logic        tc;
  } mst_t;

  mst_t m_main, m_lo, m_hi;

  function automatic mst_t mnext(input mst_t s, input logic [31:0] mask,
                                 input logic r, input logic wl,
                                 input logic [31:0] dv, input logic st_i,
                                 input logic sp, input logic au, input logic c);
    mst_t n;
    n    = s;
    n.tc = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (!wl) n.rl = dv & mask;
    if (sp) begin
      n.st = 2'd0;
    end else if (st_i) begin
      n.q  = (!wl) ? (dv & mask) : s.rl;
      n.st = 2'd1;
    end else if (s.st == 2'd1 && c) begin
      if (s.q == 32'd0) begin
        n.tc = 1'b1;
        if (au) n.q = s.rl;
        else    n.st = 2'd2;
      end else begin
        n.q = s.q - 32'd1;
      end
    end
    return n;
  endfunction

  function automatic logic mbo(input mst_t s, input logic c);
    return (s.st == 2'd1) && c && (s.q == 32'd0);
  endfunction

  always @(posedge clk) begin
    m_main <= mnext(m_main, 32'hFFFF, rst, wrl, 32'(d), strt, stop, auto, ci);
    m_lo   <= mnext(m_lo, 32'hF, rst, wrl, 32'(c_dlo), strt, stop, auto, c_ci);
    m_hi   <= mnext(m_hi, 32'hF, rst, wrl, 32'(c_dhi), strt, stop, auto,
                    mbo(m_lo, c_ci));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("q",       32'(q),       m_main.q & 32'hFFFF);
      chk("qb",      32'(qb),      ~m_main.q & 32'hFFFF);
      chk("tc",      32'(tc),      32'(m_main.tc));
      chk("bo",      32'(bo),      32'(mbo(m_main, ci)));
      chk("running", 32'(running), 32'(m_main.st == 2'd1));
      chk("lo_q",    32'(lo_q),    m_lo.q & 32'hF);
      chk("lo_tc",   32'(lo_tc),   32'(m_lo.tc));
      chk("lo_bo",   32'(lo_bo),   32'(mbo(m_lo, c_ci)));
      chk("hi_q",    32'(hi_q),    m_hi.q & 32'hF);
      chk("hi_qb",   32'(hi_qb),   ~m_hi.q & 32'hF);
      chk("hi_tc",   32'(hi_tc),   32'(m_hi.tc));
      chk("hi_run",  32'(hi_run),  32'(m_hi.st == 2'd1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int expq  [9] = '{1, 0, 2, 1, 0, 2, 1, 0, 2};
  int exptc [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int lo_seq[6] = '{0, 1, 0, 1, 0, 1};
  int hi_seq[6] = '{2, 1, 1, 0, 0, 2};
  int hi_tcs[6] = '{0, 0, 0, 0, 0, 1};
  int period;

  initial begin
    rst = 1'b1; wrl = 1'b1; strt = 1'b0; stop = 1'b0; auto = 1'b0;
    ci = 1'b0; c_ci = 1'b0; d = '0; c_dlo = 4'd1; c_dhi = 4'd2;
    tick();
    check_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("lit_rst_q",   32'(q),       32'h0);
    chk("lit_rst_qb",  32'(qb),      32'hFFFF);
    chk("lit_rst_tc",  32'(tc),      32'h0);
    chk("lit_rst_run", 32'(running), 32'h0);

    // One-shot count from 3
    d = 16'd3; wrl = 1'b0; tick();
    wrl = 1'b1; strt = 1'b1; tick();
    chk("lit_os_load", 32'(q), 32'd3);
    strt = 1'b0; ci = 1'b1;
    tick(); chk("lit_os_q2", 32'(q), 32'd2);
    tick(); chk("lit_os_q1", 32'(q), 32'd1);
    tick(); chk("lit_os_q0", 32'(q), 32'd0);
    chk("lit_os_bo", 32'(bo), 32'd1);
    tick();
    chk("lit_os_tc",   32'(tc),      32'd1);
    chk("lit_os_done", 32'(running), 32'd0);
    tick();
    chk("lit_os_tc_off", 32'(tc), 32'd0);
    chk("lit_os_hold",   32'(q),  32'd0);
    ci = 1'b0;

    // Auto reload from 2
    d = 16'd2; wrl = 1'b0; auto = 1'b1; strt = 1'b1; tick();
    chk("lit_auto_load", 32'(q), 32'd2);
    wrl = 1'b1; strt = 1'b0; ci = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("lit_auto_q",  32'(q),  32'(expq[i]));
      chk("lit_auto_tc", 32'(tc), 32'(exptc[i]));
    end
    ci = 1'b0; auto = 1'b0;

    // Gated ticks then stop at 3
    d = 16'd5; wrl = 1'b0; strt = 1'b1; tick();
    wrl = 1'b1; strt = 1'b0;
    ci = 1'b1; tick(); chk("lit_gate_4a", 32'(q), 32'd4);
    ci = 1'b0; tick(); chk("lit_gate_4b", 32'(q), 32'd4);
    ci = 1'b1; tick(); chk("lit_gate_3",  32'(q), 32'd3);
    ci = 1'b0; stop = 1'b1; tick();
    chk("lit_stop_run", 32'(running), 32'd0);
    stop = 1'b0; ci = 1'b1;
    tick(); tick(); tick();
    chk("lit_stop_hold", 32'(q), 32'd3);
    ci = 1'b0;

    // Simultaneous events
    d = 16'd7; wrl = 1'b0; strt = 1'b1; tick();
    chk("lit_wt_q", 32'(q), 32'd7);
    wrl = 1'b1; stop = 1'b1; tick();
    chk("lit_ss_run", 32'(running), 32'd0);
    chk("lit_ss_q",   32'(q),       32'd7);
    stop = 1'b0;
    d = 16'd1; wrl = 1'b0; tick();
    wrl = 1'b1; strt = 1'b0; ci = 1'b1; tick();
    chk("lit_zs_q0", 32'(q), 32'd0);
    strt = 1'b1; tick();
    chk("lit_zs_q",   32'(q),       32'd1);
    chk("lit_zs_tc",  32'(tc),      32'd0);
    chk("lit_zs_run", 32'(running), 32'd1);
    strt = 1'b0; ci = 1'b0;

    // Reset mid-run
    d = 16'd6; wrl = 1'b0; strt = 1'b1; tick();
    wrl = 1'b1; strt = 1'b0; ci = 1'b1;
    tick(); tick();
    chk("lit_mr_q4", 32'(q), 32'd4);
    rst = 1'b1; tick();
    chk("lit_mr_q",   32'(q),       32'd0);
    chk("lit_mr_tc",  32'(tc),      32'd0);
    chk("lit_mr_run", 32'(running), 32'd0);
    rst = 1'b0; ci = 1'b0; strt = 1'b1; tick();
    chk("lit_mr_reload", 32'(q), 32'd0);
    strt = 1'b0;

    // Reload 0 with auto: terminal count on every tick
    auto = 1'b1; ci = 1'b1; #1;
    chk("lit_z_bo", 32'(bo), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("lit_z_tc", 32'(tc), 32'd1);
      chk("lit_z_q",  32'(q),  32'd0);
    end
    ci = 1'b0;

    // Full-scale reload period
    d = 16'hFFFF; wrl = 1'b0; strt = 1'b1; tick();
    chk("lit_ff_load", 32'(q), 32'hFFFF);
    wrl = 1'b1; strt = 1'b0; ci = 1'b1;
    period = 0;
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (tc) begin
        period = i;
        break;
      end
    end
    chk("lit_ff_period", 32'(period), 32'd65536);
    chk("lit_ff_reload", 32'(q),      32'hFFFF);
    ci = 1'b0;

    // Cascade: low stage borrow drives high stage tick
    wrl = 1'b0; strt = 1'b1; tick();
    chk("lit_cas_lo0", 32'(lo_q), 32'd1);
    chk("lit_cas_hi0", 32'(hi_q), 32'd2);
    wrl = 1'b1; strt = 1'b0; c_ci = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("lit_cas_lo",   32'(lo_q),  32'(lo_seq[i]));
      chk("lit_cas_hi",   32'(hi_q),  32'(hi_seq[i]));
      chk("lit_cas_hitc", 32'(hi_tc), 32'(hi_tcs[i]));
    end
    c_ci = 1'b0; auto = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
